core_insn_loader: RTL and testbench

//  Per-core receive stage directly downstream of the task scheduler.
//  - Captures an instruction frame broadcast as LOAD_TIME bus parts.
//  - Captures the optional R0 init value.
//  - Serves the captured frame to the core fetch stage.
//  - Drives the core's ready back to the scheduler.
//  One instance per core; start/init bits are that core's slice of the scheduler vectors.

---
 rtl/core_insn_loader.sv | 180 ++++++++++++++++++
 tb/tb_core_insn_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_insn_loader.sv
`default_nettype none
// ============================================================================
// Module      : core_insn_loader
// Description : Per-core receive stage behind the task scheduler. Captures a
//               frame of PART_INSNS*LOAD_TIME instructions broadcast as
//               LOAD_TIME bus parts, plus an optional R0 init value. It then
//               serves the frame to the core fetch stage with a registered
//               1-cycle read. It also drives the core's ready flag back to
//               the scheduler.
//               Optional protocol checker: define INSN_LOADER_CHECK_EN to
//               add the sticky proto_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module core_insn_loader #(
  parameter int INSN_W     = 16,
  parameter int PART_INSNS = 4,
  parameter int LOAD_TIME  = 4,
  parameter int REG_W      = 8
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [((LOAD_TIME > 1) ? $clog2(LOAD_TIME) : 1)-1:0] insn_load_counter,
  input  logic [PART_INSNS*INSN_W-1:0]                   insn_data,
  input  logic                                           init_r0_en,
  input  logic [REG_W-1:0]                               init_r0,
  output logic                                           ready,
  input  logic                                           fetch_req,
  input  logic [$clog2(PART_INSNS*LOAD_TIME)-1:0]        fetch_addr,
  output logic                                           fetch_valid,
  output logic [INSN_W-1:0]                              fetch_insn,
  input  logic                                           exec_done,
  output logic                                           core_go,
  output logic                                           r0_wr_en,
  output logic [REG_W-1:0]                               r0_wr_data
`ifdef INSN_LOADER_CHECK_EN
  ,
  output logic                                           proto_err
`endif
);

  localparam int c_CNT_W       = (LOAD_TIME > 1) ? $clog2(LOAD_TIME) : 1;
  localparam int c_FRAME_INSNS = PART_INSNS * LOAD_TIME;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(LOAD_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_last_part;
  logic              w_accept;
  logic              w_enter_exec;
  logic [INSN_W-1:0] w_frame [c_FRAME_INSNS];

  assign w_last_part  = (insn_load_counter == c_LAST_CNT);
  // Parts are only taken while not executing; a start in EXEC is dropped.
  assign w_accept     = start && (r_state != ST_EXEC);
  assign w_enter_exec = (r_state != ST_EXEC) && (w_state_nxt == ST_EXEC);
  assign ready        = (r_state != ST_EXEC);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> LOAD on the first part, LOAD -> EXEC on the last
  // part, EXEC -> IDLE when the core reports it has finished the frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // A one-part frame is complete as soon as its only part arrives.
          w_state_nxt = ((LOAD_TIME == 1) && w_last_part) ? ST_EXEC : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (start && w_last_part) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame storage: the part slot is chosen by the counter, not by arrival
  // order, so a repeated index simply overwrites that part. Not reset.
  for (genvar p = 0; p < LOAD_TIME; p++) begin : g_part
    for (genvar k = 0; k < PART_INSNS; k++) begin : g_insn
      logic [INSN_W-1:0] r_word;

      // Capture instruction k of the part addressed by insn_load_counter.
      always_ff @(posedge clk) begin
        if (w_accept && (insn_load_counter == c_CNT_W'(p))) begin
          r_word <= insn_data[k*INSN_W +: INSN_W];
        end
      end

      assign w_frame[p*PART_INSNS + k] = r_word;
    end
  end

  // Start/init pulses for the core. The part that completes the frame always
  // carries a start, so its init sample is the last one and is used directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_go    <= 1'b0;
      r0_wr_en   <= 1'b0;
      r0_wr_data <= '0;
    end else begin
      core_go  <= w_enter_exec;
      r0_wr_en <= w_enter_exec && init_r0_en;
      if (w_enter_exec) begin
        r0_wr_data <= init_r0;
      end
    end
  end

  // Registered instruction fetch, served only while executing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      fetch_insn  <= '0;
    end else begin
      fetch_valid <= fetch_req && (r_state == ST_EXEC);
      if (fetch_req && (r_state == ST_EXEC)) begin
        fetch_insn <= w_frame[fetch_addr];
      end
    end
  end

`ifdef INSN_LOADER_CHECK_EN
  logic [c_CNT_W-1:0] r_prev_cnt;
  logic               w_err;

  // Flag scheduler protocol violations seen on this core's start bit.
  always_comb begin
    w_err = 1'b0;
    if (start) begin
      case (r_state)
        ST_IDLE: w_err = (insn_load_counter != '0);
        ST_LOAD: w_err = (insn_load_counter != (r_prev_cnt + c_CNT_W'(1)));
        ST_EXEC: w_err = 1'b1;
        default: w_err = 1'b0;
      endcase
    end
  end

  // Sticky error flag and the last accepted part index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err  <= 1'b0;
      r_prev_cnt <= '0;
    end else begin
      if (w_err) begin
        proto_err <= 1'b1;
      end
      if (w_accept) begin
        r_prev_cnt <= insn_load_counter;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_insn_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_insn_loader
// Description : Self-checking bench for core_insn_loader. A frame-level
//               model (instruction array, executing flag, init sample)
//               predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_insn_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  insn_load_counter = '0;
  logic [63:0] insn_data = '0;
  logic        init_r0_en = 1'b0;
  logic [7:0]  init_r0 = '0;
  logic        ready;
  logic        fetch_req = 1'b0;
  logic [3:0]  fetch_addr = '0;
  logic        fetch_valid;
  logic [15:0] fetch_insn;
  logic        exec_done = 1'b0;
  logic        core_go;
  logic        r0_wr_en;
  logic [7:0]  r0_wr_data;
`ifdef INSN_LOADER_CHECK_EN
  logic        proto_err;
  bit          m_err = 1'b0;
  int          m_prev = 0;
`endif

  core_insn_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .insn_load_counter(insn_load_counter), .insn_data(insn_data),
    .init_r0_en(init_r0_en), .init_r0(init_r0), .ready(ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_insn(fetch_insn),
    .exec_done(exec_done), .core_go(core_go),
    .r0_wr_en(r0_wr_en), .r0_wr_data(r0_wr_data)
`ifdef INSN_LOADER_CHECK_EN
    , .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  // Frame-level reference model.
  logic [15:0] m_frame [16];
  bit          m_exec    = 1'b0;
  bit          m_loading = 1'b0;
  int          n_assert  = 0;
  int          n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs for one clock edge and check every output.
  task automatic cycle();
    logic        exp_go, exp_wr, exp_fv;
    logic [15:0] exp_fi;
    logic [7:0]  exp_r0;
    int          c;
    c      = int'(insn_load_counter);
    exp_go = 1'b0;
    exp_wr = 1'b0;
    exp_r0 = '0;
    exp_fv = fetch_req && m_exec;
    exp_fi = m_frame[int'(fetch_addr)];
`ifdef INSN_LOADER_CHECK_EN
    if (start) begin
      if (m_exec) m_err = 1'b1;
      else if (!m_loading && c != 0) m_err = 1'b1;
      else if (m_loading && c != (m_prev + 1) % 4) m_err = 1'b1;
      if (!m_exec) m_prev = c;
    end
`endif
    if (!m_exec && start) begin
      for (int k = 0; k < 4; k++) m_frame[c*4 + k] = insn_data[k*16 +: 16];
      if (m_loading && c == 3) begin
        m_exec    = 1'b1;
        m_loading = 1'b0;
        exp_go    = 1'b1;
        exp_wr    = init_r0_en;
        exp_r0    = init_r0;
      end else begin
        m_loading = 1'b1;
      end
    end else if (m_exec && exec_done) begin
      m_exec = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(!m_exec));
    chk("core_go", 32'(core_go), 32'(exp_go));
    chk("r0_wr_en", 32'(r0_wr_en), 32'(exp_wr));
    if (exp_wr) chk("r0_wr_data", 32'(r0_wr_data), 32'(exp_r0));
    chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    if (exp_fv) chk("fetch_insn", 32'(fetch_insn), 32'(exp_fi));
`ifdef INSN_LOADER_CHECK_EN
    chk("proto_err", 32'(proto_err), 32'(m_err));
`endif
  endtask

  task automatic send_part(input int cnt, input logic [63:0] data,
                           input logic ien, input logic [7:0] ival);
    start             = 1'b1;
    insn_load_counter = 2'(cnt);
    insn_data         = data;
    init_r0_en        = ien;
    init_r0           = ival;
    cycle();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start     = 1'b0;
    fetch_req = 1'b0;
    exec_done = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] counting_part(input int p);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) d[k*16 +: 16] = 16'(p*4 + k + 1);
    return d;
  endfunction

  task automatic reset_model();
    m_exec    = 1'b0;
    m_loading = 1'b0;
`ifdef INSN_LOADER_CHECK_EN
    m_err  = 1'b0;
    m_prev = 0;
`endif
  endtask

  task automatic fetch(input int addr);
    fetch_req  = 1'b1;
    fetch_addr = 4'(addr);
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_frame[i] = '0;

    // Reset from time zero.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_core_go", 32'(core_go), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_insn", 32'(fetch_insn), 32'd0);
    chk("rst_r0_wr_en", 32'(r0_wr_en), 32'd0);
    chk("rst_r0_wr_data", 32'(r0_wr_data), 32'd0);
    reset = 1'b1;
    reset_model();
    idle(1);

    // Counting frame, R0 init 0x5A.
    for (int p = 0; p < 4; p++) send_part(p, counting_part(p), 1'b1, 8'h5A);
    chk("go_ready_low", 32'(ready), 32'd0);
    fetch(5);
    chk("fetch_addr5", 32'(fetch_insn), 32'h0006);
    chk("r0_data_hold", 32'(r0_wr_data), 32'h5A);
    fetch_req = 1'b0;
    exec_done = 1'b1;
    cycle();
    exec_done = 1'b0;

    // Fetch outside EXEC is never valid.
    fetch(9);
    fetch_req = 1'b0;

    // Load with a 3-cycle scheduler stall in the middle.
    send_part(0, rand64(), 1'b0, 8'h11);
    send_part(1, rand64(), 1'b0, 8'h22);
    idle(3);
    send_part(2, rand64(), 1'b1, 8'h33);
    send_part(3, rand64(), 1'b1, 8'hC4);
    // Back-to-back fetches 0, 15, 7.
    fetch(0);
    fetch(15);
    fetch(7);
    fetch_req = 1'b0;
    cycle();

    // Start while executing is ignored; frame must be unchanged.
    send_part(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'hEE);
    for (int a = 0; a < 16; a++) fetch(a);
    fetch_req = 1'b0;
`ifdef INSN_LOADER_CHECK_EN
    idle(2);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
`endif
    exec_done = 1'b1;
    cycle();
    exec_done = 1'b0;

    // New frame without R0 init; exec_done in the core_go cycle.
    for (int p = 0; p < 4; p++) send_part(p, rand64(), 1'b0, 8'h77);
    exec_done = 1'b1;
    cycle();
    exec_done = 1'b0;
    idle(1);

    // Reset asserted mid-EXEC.
    for (int p = 0; p < 4; p++) send_part(p, rand64(), 1'b1, 8'h3C);
    fetch(2);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_core_go", 32'(core_go), 32'd0);
    chk("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
    fetch_req = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_hold_ready", 32'(ready), 32'd1);
    reset = 1'b1;
    reset_model();
    idle(2);

    // Randomized frames: stalls, repeated parts, junk starts, random fetches.
    for (int f = 0; f < 25; f++) begin
      logic       ien;
      logic [7:0] ival;
      int         run;
      ien  = 1'($urandom_range(0, 1));
      ival = 8'($urandom());
      for (int p = 0; p < 4; p++) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
          insn_data  = rand64();
          fetch_req  = 1'($urandom_range(0, 1));
          fetch_addr = 4'($urandom());
          cycle();
        end
        fetch_req = 1'b0;
        if (p < 3 && $urandom_range(0, 4) == 0)
          send_part(p, rand64(), 1'($urandom_range(0, 1)), 8'($urandom()));
        send_part(p, rand64(), ien, ival);
      end
      run = int'($urandom_range(1, 8));
      for (int i = 0; i < run; i++) begin
        start             = ($urandom_range(0, 5) == 0);
        insn_load_counter = 2'($urandom());
        insn_data         = rand64();
        fetch_req         = 1'($urandom_range(0, 1));
        fetch_addr        = 4'($urandom());
        exec_done         = (i == run - 1);
        cycle();
      end
      start     = 1'b0;
      exec_done = 1'b0;
      fetch_req = 1'b0;
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
